mac_controller: RTL and testbench

FSM that sequences the shift-add multiply-accumulate datapath built from the 1-bit load/clear registers (Reg1b-style cells with `ld`/`init0` controls).
- Per operation: loads operands A and B, clears the partial product, runs WIDTH shift-add steps, folds the product into the accumulator, then pulses done.
- Drives only control strobes. Reads one status bit (multiplier LSB) back from the datapath.

---
 rtl/mac_ctrl_pkg.sv | 14 +
 rtl/mac_step_counter.sv | 27 ++
 rtl/mac_controller.sv | 113 +++++++++++
 tb/tb_mac_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared state encoding for the MAC sequencer
package mac_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mac_step_counter.sv
// rtl/mac_step_counter.sv - shift-add step counter with terminal-count flag
module mac_step_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic init0,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (init0) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mac_controller.sv
// rtl/mac_controller.sv - control FSM for the shift-add MAC datapath
// MAC_OVF_EN adds acc_cout input and sticky ovf output.
module mac_controller
  import mac_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr_acc,
  input  logic b_lsb,
  output logic ready,
  output logic done,
  output logic ld_a,
  output logic ld_b,
  output logic init0_p,
  output logic init0_acc,
  output logic add_p,
  output logic shift_pb,
  output logic ld_acc
`ifdef MAC_OVF_EN
  ,
  input  logic acc_cout,
  output logic ovf
`endif
);

  state_e state_q, state_d;
  logic   clr_q, clr_d;
  logic   tc;
  logic   ready_q, done_q, load_q, init0_acc_q, mul_q, ld_acc_q;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          clr_d   = clr_acc;
        end
      end
      S_LOAD:  state_d = S_MUL;
      S_MUL:   if (tc) state_d = S_ACC;
      S_ACC:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they stay Moore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clr_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      init0_acc_q <= 1'b0;
      mul_q       <= 1'b0;
      ld_acc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      ready_q     <= (state_d == S_IDLE);
      done_q      <= (state_d == S_DONE);
      load_q      <= (state_d == S_LOAD);
      init0_acc_q <= (state_d == S_LOAD) && clr_d;
      mul_q       <= (state_d == S_MUL);
      ld_acc_q    <= (state_d == S_ACC);
    end
  end

  mac_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .init0 (load_q),
    .inc   (mul_q),
    .tc    (tc)
  );

  assign ready     = ready_q;
  assign done      = done_q;
  assign ld_a      = load_q;
  assign ld_b      = load_q;
  assign init0_p   = load_q;
  assign init0_acc = init0_acc_q;
  assign add_p     = b_lsb & mul_q;
  assign shift_pb  = mul_q;
  assign ld_acc    = ld_acc_q;

`ifdef MAC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == S_ACC) && acc_cout) begin
      ovf_q <= 1'b1;
    end else if ((state_q == S_LOAD) && clr_q) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mac_controller.sv
// tb/tb_mac_controller.sv - table-driven check of mac_controller sequencing
module tb_mac_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clr_acc = 1'b0;
  logic b_lsb;
  logic ready, done, ld_a, ld_b, init0_p, init0_acc, add_p, shift_pb, ld_acc;
  logic [7:0] b_val = 8'h00;
  logic [7:0] b_reg = 8'h00;
`ifdef MAC_OVF_EN
  logic acc_cout;
  logic ovf;
  logic cout_en = 1'b0;
  assign acc_cout = cout_en & ld_acc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_controller #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clr_acc   (clr_acc),
    .b_lsb     (b_lsb),
    .ready     (ready),
    .done      (done),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .init0_p   (init0_p),
    .init0_acc (init0_acc),
    .add_p     (add_p),
    .shift_pb  (shift_pb),
    .ld_acc    (ld_acc)
`ifdef MAC_OVF_EN
    ,
    .acc_cout  (acc_cout),
    .ovf       (ovf)
`endif
  );

  // Multiplier shift register of the datapath, feeding b_lsb back.
  always @(posedge clk) begin
    if (ld_b) b_reg <= b_val;
    else if (shift_pb) b_reg <= {1'b0, b_reg[7:1]};
  end
  assign b_lsb = b_reg[0];

  typedef struct {
    logic       start;
    logic       clr;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t tv[24];

  function automatic logic [8:0] outs();
    return {ready, done, ld_a, ld_b, init0_p, init0_acc, add_p, shift_pb, ld_acc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic c, input logic [7:0] b,
                       output int muls, output int dones);
    start = 1'b1; clr_acc = c; b_val = b;
    tick();
    start = 1'b0; clr_acc = 1'b0;
    muls = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (shift_pb) muls++;
      if (done) dones++;
      if (ready) break;
      tick();
    end
    check("op_returns_idle", ready, 1);
  endtask

  initial begin
    int muls, dones, shifts;
    logic [7:0] seq;

    // Op 1: clr_acc=1, B=0x0D. Op 2: clr_acc=0, B=0x0B, start/clr wiggled in MUL.
    tv[0] = '{1'b1, 1'b1, 8'h0D, 9'b001111000};
    seq = 8'h0D;
    for (int i = 0; i < 8; i++) tv[1+i] = '{1'b0, 1'b0, 8'h0D, {6'b000000, seq[i], 2'b10}};
    tv[9]  = '{1'b0, 1'b0, 8'h0D, 9'b000000001};
    tv[10] = '{1'b0, 1'b0, 8'h0D, 9'b010000000};
    tv[11] = '{1'b0, 1'b0, 8'h0D, 9'b100000000};
    tv[12] = '{1'b1, 1'b0, 8'h0B, 9'b001110000};
    seq = 8'h0B;
    for (int i = 0; i < 8; i++) tv[13+i] = '{(i == 2 || i == 3), (i == 2), 8'h0B,
                                             {6'b000000, seq[i], 2'b10}};
    tv[21] = '{1'b0, 1'b0, 8'h0B, 9'b000000001};
    tv[22] = '{1'b0, 1'b0, 8'h0B, 9'b010000000};
    tv[23] = '{1'b0, 1'b0, 8'h0B, 9'b100000000};

    // Reset held for two cycles
    tick(); tick();
    check("reset_outputs", outs(), 9'b100000000);
`ifdef MAC_OVF_EN
    check("reset_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();
    check("idle_after_reset", outs(), 9'b100000000);

    for (int k = 0; k < 24; k++) begin
      start = tv[k].start; clr_acc = tv[k].clr; b_val = tv[k].b;
      tick();
      check($sformatf("vec%0d", k), outs(), tv[k].exp);
    end
    start = 1'b0; clr_acc = 1'b0;

    // start held high: back-to-back operations, 12 cycles apart
    shifts = 0;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (shift_pb) shifts++;
      check($sformatf("held_done_c%0d", c), done, (c == 11 || c == 23));
      check($sformatf("held_ready_c%0d", c), ready, (c == 12 || c == 24));
    end
    start = 1'b0;
    check("held_mul_cycles_30", shifts, 21);
    for (int i = 0; i < 20 && !ready; i++) begin
      tick();
      if (shift_pb) shifts++;
    end
    check("held_ready_back", ready, 1);
    check("held_mul_cycles_total", shifts, 24);

    // Asynchronous reset in the fifth MUL cycle
    start = 1'b1; clr_acc = 1'b0; b_val = 8'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mul5_before_rst", outs(), 9'b000000110);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", outs(), 9'b100000000);
    dones = 0;
    tick(); if (done) dones++;
    tick(); if (done) dones++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    check("no_done_after_abort", dones, 0);
    check("idle_after_abort", outs(), 9'b100000000);
    do_op(1'b0, 8'h81, muls, dones);
    check("post_abort_muls", muls, 8);
    check("post_abort_dones", dones, 1);

`ifdef MAC_OVF_EN
    cout_en = 1'b1;
    do_op(1'b1, 8'h01, muls, dones);
    cout_en = 1'b0;
    check("ovf_set", ovf, 1);
    do_op(1'b0, 8'h01, muls, dones);
    check("ovf_sticky", ovf, 1);
    start = 1'b1; clr_acc = 1'b1; b_val = 8'h01;
    tick();
    start = 1'b0; clr_acc = 1'b0;
    check("ovf_held_in_load", ovf, 1);
    tick();
    check("ovf_cleared_after_load", ovf, 0);
    for (int i = 0; i < 20 && !ready; i++) tick();
    check("ovf_op_idle", ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
